cmd_parser: RTL and testbench
=============================

# cmd_parser

Line-oriented command decoder for the pseudo-terminal. It collects ASCII characters from the keyboard/UART receive path into a line buffer and folds them to upper case. On carriage return it parses the line into a keyword and an optional decimal argument. It then issues a one-cycle one-hot `op_code` plus a stable argument byte `a` to the response stages (greeting, arithmetic, echo, etc.), which sit directly downstream.

## Interface
Parameters:
- `LINE_LEN`, 16: line buffer depth in characters, minimum 8.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received ASCII character.
- `rx_valid` in 1: `rx_data` valid this cycle.
- `rx_ready` out 1: parser accepts a character this cycle; high only in COLLECT and DISCARD.
- `op_code` out 11: one-hot command, nonzero for exactly one cycle.
- `op_valid` out 1: high in the same cycle `op_code` is nonzero.
- `a` out 8: argument byte; updated in the `op_valid` cycle, held until the next `op_valid`.
- `err` out 1: one-cycle pulse on an unknown keyword, a bad argument, or overflow.
- `busy` out 1: high in PARSE, MATCH and EMIT.

## Operation
- Reset values: `rx_ready`=1, `op_code`=0, `op_valid`=0, `a`=0, `err`=0, `busy`=0. The buffer is emptied (count=0) and the state is COLLECT.
- Character transfer: a character is taken when `rx_valid && rx_ready`.
- States: COLLECT, DISCARD, PARSE, MATCH, EMIT.
- COLLECT, per accepted character:
  - 0x61-0x7A are converted to upper case, then stored.
  - 0x08 (backspace) decrements the count if nonzero; otherwise it is ignored.
  - 0x0A is ignored.
  - 0x20 received while count=0 is ignored, so leading spaces are stripped.
  - 0x0D with count=0 is ignored and produces no output.
  - 0x0D with count>0 moves to PARSE.
  - Any other character is stored at index count, and count increments.
  - A store attempted while count=LINE_LEN moves to DISCARD and the character is dropped.
- DISCARD: all characters are consumed and dropped. On 0x0D, pulse `err` for one cycle, clear count, and go to COLLECT. `op_valid` stays low.
- PARSE: scan the buffer at one index per cycle, from 0 to count-1.
  - Keyword: the characters before the first space, up to 5 characters. A keyword longer than 5 characters sets the bad flag.
  - Characters after the first space form the argument. Repeated spaces there are skipped.
  - Each digit updates `arg = min(arg*10 + d, 255)`. Arithmetic is 8-bit, saturating at 255.
  - A non-digit, non-space character in the argument field sets the bad flag.
  - With no argument, arg=0.
- MATCH: compare the keyword, space-padded to 5, against the table. Bit index and keyword:
  - 0 CLR, 1 HELP, 2 ADD, 3 SUB, 4 MUL, 5 HI, 6 ECHO, 7 LED, 8 RAND, 9 TIME, 10 BYE.
  - Matching is an exact match only. "HIX" and "H" do not match.
- EMIT, lasts one cycle:
  - Keyword matched and bad flag clear: `op_code` = the one-hot bit, `op_valid`=1, `a`=arg.
  - Otherwise: `op_code`=0, `op_valid`=0, `err`=1, and `a` is unchanged.
  - Then clear count and return to COLLECT.
- Characters presented while `rx_ready`=0 are not consumed. The upstream source must hold them.
- Reset asserted mid-line or mid-parse aborts immediately to the reset values. No partial `op_code` is ever emitted.

## Timing
- The 0x0D is accepted in cycle N. PARSE runs in cycles N+1 .. N+count. MATCH is in cycle N+count+1. `op_code`/`op_valid`/`err` are valid in cycle N+count+2, registered.
- `rx_ready` drops in cycle N+1 and returns high in cycle N+count+3.
- `busy` = 1 from N+1 through N+count+2 inclusive.
- DISCARD terminating 0x0D in cycle N: `err` is high in N+1, and `rx_ready` stays high.
- Back-to-back lines: the first character of the next line can be accepted in the cycle after EMIT.
- All outputs are registered, with no combinational path from `rx_*` to outputs, except `rx_ready`, which is decoded from the state register.

## Test plan
- After reset, send "hi\r": `op_code`=11'b00000100000 and `op_valid`=1 for exactly 1 cycle at N+4; `a`=0; `err` stays 0.
- Send "  add 37\r": `op_code`=11'b00000000100, `a`=37. Then send "mul 999\r": `op_code`=11'b00000010000, `a`=255 (saturated).
- Send "ECHX\b\bHO 5\r": the line resolves to "ECHO 5". Expect `op_code`=bit 6, `a`=5. Check that `a` holds 5 through 20 idle cycles.
- Send "foo\r", then "led 1x\r", then "helpme\r": `err` pulses 3 times, `op_valid` never asserts, and `a` keeps its previous value.
- With LINE_LEN=16, send 20 non-CR characters then "\r": a single `err` pulse 1 cycle after the CR, and no `op_valid`. A following "bye\r" gives `op_code`=bit 10.
- Hold `rx_valid` high during PARSE and check that the character is not consumed. Separately, assert `rst_n`=0 during PARSE: all outputs go to reset values at once, and no `op_valid` follows.

Source files
------------

// File: rtl/cmd_parser_if.sv
// cmd_parser_if: bundles the receive handshake and the command output bus of
// the line-oriented command parser.
//   rx_data  / rx_valid / rx_ready : character stream into the parser
//   op_code / op_valid / a         : one-hot command pulse plus held argument
//   err / busy                     : error pulse and parse-in-progress flag
// master: the side that supplies characters and consumes commands.
// slave : the parser itself.
interface cmd_parser_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [10:0] op_code;
  logic        op_valid;
  logic [7:0]  a;
  logic        err;
  logic        busy;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  op_code,
    input  op_valid,
    input  a,
    input  err,
    input  busy
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output op_code,
    output op_valid,
    output a,
    output err,
    output busy
  );

endinterface

// File: rtl/cmd_parser.sv
// cmd_parser: collects ASCII characters into an upper-cased line buffer, and on
// carriage return parses the line into a keyword (up to 5 chars) and an optional
// saturating decimal argument, then emits a one-cycle one-hot op_code.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : cmd_parser_if.slave (rx_data/rx_valid/rx_ready in,
//            op_code/op_valid/a/err/busy out, all registered except rx_ready)
module cmd_parser #(
  parameter int unsigned LINE_LEN = 16
) (
  input logic         clk,
  input logic         rst_n,
  cmd_parser_if.slave bus
);

  localparam int unsigned CW     = $clog2(LINE_LEN + 1);
  localparam int unsigned IW     = $clog2(LINE_LEN);
  localparam int unsigned KW_MAX = 5;
  localparam int unsigned KLW    = 3;
  localparam int unsigned N_OPS  = 11;
  localparam int unsigned MACW   = 12;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  // Keyword table, space padded; entry i drives op_code bit i.
  localparam logic [N_OPS-1:0][8*KW_MAX-1:0] KW_TABLE = {
    "BYE  ", "TIME ", "RAND ", "LED  ", "ECHO ", "HI   ",
    "MUL  ", "SUB  ", "ADD  ", "HELP ", "CLR  "
  };

  typedef enum logic [2:0] {
    S_COLLECT,
    S_DISCARD,
    S_PARSE,
    S_MATCH,
    S_EMIT
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_count;
  logic [CW-1:0]            r_idx;
  logic [7:0]               r_buf [LINE_LEN];
  logic [KW_MAX-1:0][7:0]   r_kw;
  logic [KLW-1:0]           r_kw_len;
  logic                     r_in_arg;
  logic                     r_bad;
  logic [7:0]               r_arg;
  logic [N_OPS-1:0]         r_op_code;
  logic                     r_op_valid;
  logic [7:0]               r_a;
  logic                     r_err;
  logic                     r_busy;

  logic                     w_rx_ready;
  logic                     w_take;
  logic                     w_is_lower;
  logic [7:0]               w_char_up;
  logic                     w_full;
  logic                     w_storable;
  logic                     w_store;
  logic                     w_overflow;
  logic [7:0]               w_pc;
  logic                     w_pc_digit;
  logic [MACW-1:0]          w_arg_mac;
  logic [7:0]               w_arg_sat;
  logic                     w_last;
  logic [N_OPS-1:0]         w_match;

  // Ready is a pure state decode so upstream sees it without a flop delay.
  assign w_rx_ready = (r_state == S_COLLECT) || (r_state == S_DISCARD);
  assign w_take     = bus.rx_valid && w_rx_ready;

  // Character classification for the collect path.
  assign w_is_lower = (bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h7A);
  assign w_char_up  = w_is_lower ? (bus.rx_data - 8'h20) : bus.rx_data;
  assign w_full     = (r_count == CW'(LINE_LEN));
  assign w_storable = (bus.rx_data != CH_CR) && (bus.rx_data != CH_BS) &&
                      (bus.rx_data != CH_LF) &&
                      !((bus.rx_data == CH_SP) && (r_count == '0));
  assign w_store    = w_take && (r_state == S_COLLECT) && w_storable && !w_full;
  assign w_overflow = w_take && (r_state == S_COLLECT) && w_storable && w_full;

  // Parse datapath: current buffer character and saturating decimal accumulate.
  assign w_pc       = r_buf[r_idx[IW-1:0]];
  assign w_pc_digit = (w_pc >= 8'h30) && (w_pc <= 8'h39);
  assign w_arg_mac  = MACW'(r_arg) * MACW'(10) + MACW'(w_pc - 8'h30);
  assign w_arg_sat  = (w_arg_mac > MACW'(255)) ? 8'hFF : w_arg_mac[7:0];
  assign w_last     = (r_idx == (r_count - CW'(1)));

  // Exact keyword compare against every table entry.
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < N_OPS; i++) begin
      w_match[i] = (r_kw == KW_TABLE[i]);
    end
  end

  assign bus.rx_ready = w_rx_ready;
  assign bus.op_code  = r_op_code;
  assign bus.op_valid = r_op_valid;
  assign bus.a        = r_a;
  assign bus.err      = r_err;
  assign bus.busy     = r_busy;

  // Line buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINE_LEN; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_store) begin
      r_buf[r_count[IW-1:0]] <= w_char_up;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_COLLECT;
      r_count    <= '0;
      r_idx      <= '0;
      r_kw       <= {KW_MAX{CH_SP}};
      r_kw_len   <= '0;
      r_in_arg   <= 1'b0;
      r_bad      <= 1'b0;
      r_arg      <= '0;
      r_op_code  <= '0;
      r_op_valid <= 1'b0;
      r_a        <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_take) begin
            if (bus.rx_data == CH_CR) begin
              // Empty lines produce nothing; otherwise arm the parse scan.
              if (r_count != '0) begin
                r_state  <= S_PARSE;
                r_busy   <= 1'b1;
                r_idx    <= '0;
                r_kw     <= {KW_MAX{CH_SP}};
                r_kw_len <= '0;
                r_in_arg <= 1'b0;
                r_bad    <= 1'b0;
                r_arg    <= '0;
              end
            end else if (bus.rx_data == CH_BS) begin
              if (r_count != '0) begin
                r_count <= r_count - CW'(1);
              end
            end else if (w_store) begin
              r_count <= r_count + CW'(1);
            end else if (w_overflow) begin
              r_state <= S_DISCARD;
            end
          end
        end

        S_DISCARD: begin
          if (w_take && (bus.rx_data == CH_CR)) begin
            r_err   <= 1'b1;
            r_count <= '0;
            r_state <= S_COLLECT;
          end
        end

        S_PARSE: begin
          if (!r_in_arg) begin
            // First space ends the keyword; a sixth keyword char marks the line bad.
            if (w_pc == CH_SP) begin
              r_in_arg <= 1'b1;
            end else if (r_kw_len == KLW'(KW_MAX)) begin
              r_bad <= 1'b1;
            end else begin
              r_kw[KLW'(KW_MAX - 1) - r_kw_len] <= w_pc;
              r_kw_len <= r_kw_len + KLW'(1);
            end
          end else if (w_pc_digit) begin
            r_arg <= w_arg_sat;
          end else if (w_pc != CH_SP) begin
            r_bad <= 1'b1;
          end
          r_idx <= r_idx + CW'(1);
          if (w_last) begin
            r_state <= S_MATCH;
          end
        end

        S_MATCH: begin
          if ((w_match != '0) && !r_bad) begin
            r_op_code  <= w_match;
            r_op_valid <= 1'b1;
            r_a        <= r_arg;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= S_EMIT;
        end

        S_EMIT: begin
          r_op_code  <= '0;
          r_op_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_count    <= '0;
          r_state    <= S_COLLECT;
        end

        default: begin
          r_state <= S_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed and randomized lines against a string-level model of
// the command parser (line editing, keyword split, saturating argument, table).
module tb_cmd_parser;

  localparam int LINE_LEN = 16;
  localparam int GUARD    = 100;

  typedef byte unsigned byte_q_t[$];

  typedef struct {
    int          kind;   // 0 none, 1 command, 2 parse error, 3 overflow error
    logic [10:0] code;
    logic [7:0]  arg;
    int          plen;
  } exp_t;

  string KW_NAMES [11] = '{"CLR", "HELP", "ADD", "SUB", "MUL", "HI",
                           "ECHO", "LED", "RAND", "TIME", "BYE"};
  string POOL [14] = '{"CLR", "HELP", "ADD", "SUB", "MUL", "HI", "ECHO",
                       "LED", "RAND", "TIME", "BYE", "FOO", "HELPME", "HIX"};

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_opv;
  int   n_err;
  int   exp_opv;
  int   exp_err;
  logic [7:0] model_a;

  cmd_parser_if bus_if ();

  cmd_parser #(.LINE_LEN(LINE_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Pulse counting and one-hot sanity on every output cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.op_valid) n_opv++;
      if (bus_if.err) n_err++;
      if (bus_if.op_valid || (bus_if.op_code != '0))
        check("onehot_valid", 32'(bus_if.op_valid && $onehot(bus_if.op_code)), 32'd1);
    end
  end

  function automatic byte_q_t s2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: edit the line, split at the first space, look the keyword up.
  function automatic exp_t model(input byte_q_t s);
    exp_t    e;
    byte_q_t q;
    bit      disc;
    e.kind = 0; e.code = '0; e.arg = '0; e.plen = 0;
    disc = 0;
    foreach (s[i]) begin
      int c;
      c = int'(s[i]);
      if (disc) begin
        if (c == 13) begin e.kind = 3; return e; end
        continue;
      end
      if (c == 13) begin
        int sp, kwlen, arg, match;
        bit bad;
        if (q.size() == 0) continue;
        e.plen = q.size();
        sp = -1;
        for (int k = 0; k < q.size(); k++) if (q[k] == 32) begin sp = k; break; end
        kwlen = (sp < 0) ? q.size() : sp;
        bad = (kwlen > 5);
        arg = 0;
        if (sp >= 0) begin
          for (int k = sp + 1; k < q.size(); k++) begin
            if (q[k] == 32) continue;
            if (q[k] >= 48 && q[k] <= 57) begin
              arg = arg * 10 + (int'(q[k]) - 48);
              if (arg > 255) arg = 255;
            end else bad = 1;
          end
        end
        match = -1;
        for (int t = 0; t < 11; t++) begin
          if (KW_NAMES[t].len() == kwlen) begin
            bit eq;
            eq = 1;
            for (int j = 0; j < kwlen; j++) if (int'(KW_NAMES[t][j]) != int'(q[j])) eq = 0;
            if (eq) match = t;
          end
        end
        if (match >= 0 && !bad) begin
          e.kind = 1; e.code = 11'(1) << match; e.arg = 8'(arg);
        end else e.kind = 2;
        return e;
      end
      if (c == 8) begin if (q.size() > 0) void'(q.pop_back()); continue; end
      if (c == 10) continue;
      if (c == 32 && q.size() == 0) continue;
      if (c >= 97 && c <= 122) c = c - 32;
      if (q.size() == LINE_LEN) begin disc = 1; continue; end
      q.push_back(8'(c));
    end
    return e;
  endfunction

  task automatic send_char(input byte unsigned c);
    int g;
    @(negedge clk);
    bus_if.rx_data  = c;
    bus_if.rx_valid = 1'b1;
    g = 0;
    while (!bus_if.rx_ready && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) check("rx_ready_timeout", 32'(g), 32'd0);
    @(posedge clk);
    #1 bus_if.rx_valid = 1'b0;
  endtask

  // Sends a line (last byte CR) and checks the response cycle by cycle.
  task automatic run_line(input byte_q_t line, input byte_q_t pre,
                          input bit hold, input byte unsigned hold_ch);
    exp_t    e;
    byte_q_t full;
    bit      ok;
    full = {pre, line};
    e = model(full);
    foreach (line[i]) send_char(line[i]);
    if (hold) begin
      bus_if.rx_data  = hold_ch;
      bus_if.rx_valid = 1'b1;
    end
    if (e.kind == 1 || e.kind == 2) begin
      ok = 1;
      for (int k = 1; k <= e.plen + 1; k++) begin
        @(negedge clk);
        if (bus_if.op_valid || bus_if.err || !bus_if.busy || bus_if.rx_ready) ok = 0;
      end
      check("parse_quiet", 32'(ok), 32'd1);
      @(negedge clk);
      if (e.kind == 1) begin
        model_a = e.arg;
        exp_opv++;
      end else exp_err++;
      check("emit_op_valid", 32'(bus_if.op_valid), 32'(e.kind == 1));
      check("emit_op_code", 32'(bus_if.op_code), 32'(e.code));
      check("emit_a", 32'(bus_if.a), 32'(model_a));
      check("emit_err", 32'(bus_if.err), 32'(e.kind == 2));
      check("emit_busy", 32'(bus_if.busy), 32'd1);
      @(negedge clk);
      check("post_op_valid", 32'(bus_if.op_valid), 32'd0);
      check("post_err", 32'(bus_if.err), 32'd0);
      check("post_busy", 32'(bus_if.busy), 32'd0);
      check("post_rx_ready", 32'(bus_if.rx_ready), 32'd1);
    end else if (e.kind == 3) begin
      exp_err++;
      @(negedge clk);
      check("ovf_err", 32'(bus_if.err), 32'd1);
      check("ovf_rx_ready", 32'(bus_if.rx_ready), 32'd1);
      check("ovf_op_valid", 32'(bus_if.op_valid), 32'd0);
      @(negedge clk);
      check("ovf_err_drop", 32'(bus_if.err), 32'd0);
    end else begin
      @(negedge clk);
      check("none_busy", 32'(bus_if.busy), 32'd0);
      check("none_out", 32'({bus_if.op_valid, bus_if.err}), 32'd0);
    end
  endtask

  function automatic byte_q_t rand_line();
    byte_q_t q;
    string   w;
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) q.push_back(8'h20);
    if ($urandom_range(0, 3) == 0) begin
      q.push_back(8'h51);
      q.push_back(8'h08);
    end
    w = POOL[$urandom_range(0, 13)];
    for (int j = 0; j < w.len(); j++) begin
      byte unsigned c;
      c = w[j];
      if ($urandom_range(0, 1) == 1) c = c + 8'd32;
      q.push_back(c);
    end
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < int'($urandom_range(1, 2)); i++) q.push_back(8'h20);
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      if ($urandom_range(0, 7) == 0) q.push_back(8'h58);
    end
    if ($urandom_range(0, 9) == 0) q.push_back(8'h0A);
    if ($urandom_range(0, 9) == 0) for (int i = 0; i < LINE_LEN; i++) q.push_back(8'h41);
    q.push_back(8'h0D);
    return q;
  endfunction

  initial begin
    byte_q_t nopre;
    byte_q_t q;
    int      bad;
    int      snap;
    n_checks = 0; n_errors = 0; n_opv = 0; n_err = 0;
    exp_opv = 0; exp_err = 0; model_a = 8'd0;
    rst_n = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(bus_if.rx_ready), 32'd1);
    check("rst_op_code", 32'(bus_if.op_code), 32'd0);
    check("rst_op_valid", 32'(bus_if.op_valid), 32'd0);
    check("rst_a", 32'(bus_if.a), 32'd0);
    check("rst_err", 32'(bus_if.err), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    rst_n = 1'b1;

    run_line(s2q("hi\015"), nopre, 0, 8'h00);
    run_line(s2q("  add 37\015"), nopre, 0, 8'h00);
    run_line(s2q("mul 999\015"), nopre, 0, 8'h00);
    run_line(s2q("ECHX\010\010HO 5\015"), nopre, 0, 8'h00);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.a !== model_a) bad++;
    end
    check("a_hold_idle", 32'(bad), 32'd0);
    run_line(s2q("foo\015"), nopre, 0, 8'h00);
    run_line(s2q("led 1x\015"), nopre, 0, 8'h00);
    run_line(s2q("helpme\015"), nopre, 0, 8'h00);
    run_line(s2q("\015"), nopre, 0, 8'h00);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'h5A);
    q.push_back(8'h0D);
    run_line(q, nopre, 0, 8'h00);
    run_line(s2q("bye\015"), nopre, 0, 8'h00);

    // Character held during PARSE must survive to start the next line.
    run_line(s2q("clr\015"), nopre, 1, 8'h42);
    run_line(s2q("ye\015"), s2q("B"), 0, 8'h00);

    for (int n = 0; n < 40; n++) run_line(rand_line(), nopre, 0, 8'h00);

    // Reset in the middle of a parse.
    q = s2q("add 7\015");
    foreach (q[i]) send_char(q[i]);
    @(negedge clk);
    @(negedge clk);
    snap = n_opv;
    rst_n = 1'b0;
    #1;
    check("midrst_rx_ready", 32'(bus_if.rx_ready), 32'd1);
    check("midrst_op_code", 32'(bus_if.op_code), 32'd0);
    check("midrst_op_valid", 32'(bus_if.op_valid), 32'd0);
    check("midrst_a", 32'(bus_if.a), 32'd0);
    check("midrst_err", 32'(bus_if.err), 32'd0);
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    model_a = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_op", 32'(n_opv), 32'(snap));
    run_line(s2q("time 12\015"), nopre, 0, 8'h00);

    check("total_op_valid", 32'(n_opv), 32'(exp_opv));
    check("total_err", 32'(n_err), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
